// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host state encoding, command bytes and parity helper.
package ps2_pkg;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_REQ       = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_ACK       = 3'd4;
    localparam state_t ST_WAIT_IDLE = 3'd5;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser with falling-edge detect; idles high like the PS/2 lines.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fe
);
    logic s1, prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            dout <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= din;
            dout <= s1;
            prev <= dout;
        end
    end
    assign fe = prev & ~dout;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain enables.
// Define PS2_HOST_TX_RETRY_EN to retransmit once after a NACK or watchdog expiry.
import ps2_pkg::*;
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [9:0]       shreg;
    logic             data_oe_r, ack_r;
    logic             clk_s, data_s, clk_fe, unused_data_fe;
    logic             wd_active, expire;
`ifdef PS2_HOST_TX_RETRY_EN
    logic             retried;
`endif
    ps2_sync_edge u_clk_sync (.clk(clk), .rst(rst), .din(ps2_clk_in), .dout(clk_s), .fe(clk_fe));
    ps2_sync_edge u_data_sync (.clk(clk), .rst(rst), .din(ps2_data_in), .dout(data_s), .fe(unused_data_fe));
    assign tx_ready    = state == ST_IDLE;
    assign tx_busy     = ~tx_ready;
    assign ps2_clk_oe  = state == ST_INHIBIT;
    assign ps2_data_oe = data_oe_r;
    assign wd_active   = state inside {ST_SEND, ST_ACK, ST_WAIT_IDLE};
    // a device edge arriving on the expiry cycle keeps the transfer alive
    assign expire      = wd_active && cnt == '0 && !clk_fe;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data_oe_r <= 1'b0;
            ack_r     <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            tx_ack_ok <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            tx_ack_ok <= 1'b0;
            if (wd_active) cnt <= clk_fe ? WD_LOAD : cnt - 1'b1;
            if (expire) begin
                data_oe_r <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (!retried) begin
                    retried <= 1'b1;
                    cnt     <= INH_LOAD;
                    state   <= ST_INHIBIT;
                end else begin
                    state   <= ST_IDLE;
                    tx_done <= 1'b1;
                    tx_err  <= 1'b1;
                end
`else
                state   <= ST_IDLE;
                tx_done <= 1'b1;
                tx_err  <= 1'b1;
`endif
            end else begin
                case (state)
                    ST_IDLE: if (tx_valid) begin
                        shreg <= {1'b1, odd_parity(tx_data), tx_data};
                        cnt   <= INH_LOAD;
                        state <= ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                        retried <= 1'b0;
`endif
                    end
                    ST_INHIBIT: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            data_oe_r <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        cnt   <= WD_LOAD;
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                    ST_SEND: if (clk_fe) begin
                        data_oe_r <= ~shreg[idx];
                        idx       <= idx + 4'd1;
                        if (idx == 4'd9) state <= ST_ACK;
                    end
                    ST_ACK: if (clk_fe) begin
                        ack_r <= ~data_s;
                        state <= ST_WAIT_IDLE;
                    end
                    ST_WAIT_IDLE: if (clk_s && data_s) begin
`ifdef PS2_HOST_TX_RETRY_EN
                        if (!ack_r && !retried) begin
                            retried <= 1'b1;
                            cnt     <= INH_LOAD;
                            state   <= ST_INHIBIT;
                        end else begin
                            state     <= ST_IDLE;
                            tx_done   <= 1'b1;
                            tx_ack_ok <= ack_r;
                        end
`else
                        state     <= ST_IDLE;
                        tx_done   <= 1'b1;
                        tx_ack_ok <= ack_r;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
